// File: rtl/pti_pkg.sv
// pti_pkg: shared encodings and widths for the pulse-train input capture block.
package pti_pkg;
    localparam int CNT_W = 32;
    localparam logic [1:0] RAMP_IDLE  = 2'd0;
    localparam logic [1:0] RAMP_ACCEL = 2'd1;
    localparam logic [1:0] RAMP_CONST = 2'd2;
    localparam logic [1:0] RAMP_DECEL = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_DONE} state_t;
endpackage

// File: rtl/pti_input_filter.sv
// pti_input_filter: synchronizes pulse_in, rejects short glitches and flags rising edges
module pti_input_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise_pulse
);
    logic [1:0] sync;
    logic       filt;
    logic       filt_q;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            filt   <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
        end else begin
            sync   <= {sync[0], pulse_in};
            filt_q <= filt;
            // cnt tracks how many consecutive samples disagree with the accepted level
            if (sync[1] == filt)
                cnt <= '0;
            else if (cnt == 4'(FILT_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else
                cnt <= cnt + 4'd1;
        end
    end

    assign rise_pulse = filt & ~filt_q;
endmodule

// File: rtl/pti_capture.sv
// pti_capture: counts step pulses, measures periods in us, classifies ramp phase,
// detects stalls and flags completion at an expected pulse count.
module pti_capture
    import pti_pkg::*;
#(
    parameter int CLK_PER_US = 50,
    parameter int FILT_LEN   = 3,
    parameter int TOL_US     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] timeout_us,
    input  logic [CNT_W-1:0] pulse_expected,
    output logic [CNT_W-1:0] pulse_count,
    output logic [CNT_W-1:0] period_us,
    output logic             period_valid,
    output logic [1:0]       ramp_state,
    output logic             stalled,
    output logic             done
);
    localparam int PRE_W = $clog2(CLK_PER_US) > 0 ? $clog2(CLK_PER_US) : 1;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W:0]   TOL = (CNT_W + 1)'(TOL_US);

    state_t           state, state_nxt;
    logic             rise, edge_ok, active, us_tick, hit_done, timeout_hit, first;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] us_cnt, cnt_inc;
    logic [CNT_W:0]   p, pp;
    logic [1:0]       ramp_new;

    pti_input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk       (clk),
        .rst       (rst | clear),
        .pulse_in  (pulse_in),
        .rise_pulse(rise)
    );

    assign edge_ok     = rise && enable && state != S_DONE;
    assign active      = enable && (state == S_RUN || state == S_STALL);
    assign us_tick     = active && pre == PRE_W'(CLK_PER_US - 1);
    assign cnt_inc     = pulse_count == MAX ? MAX : pulse_count + 1'b1;
    assign hit_done    = pulse_expected != '0 && cnt_inc == pulse_expected;
    assign timeout_hit = timeout_us != '0 && us_cnt == timeout_us;

    always_comb begin
        p         = {1'b0, us_cnt};
        pp        = {1'b0, period_us};
        ramp_new  = first ? RAMP_CONST : (p + TOL < pp) ? RAMP_ACCEL : (p > pp + TOL) ? RAMP_DECEL : RAMP_CONST;
        state_nxt = state;
        if (edge_ok)
            state_nxt = hit_done ? S_DONE : S_RUN;
        else if (active && state == S_RUN && timeout_hit)
            state_nxt = S_STALL;
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pulse_count  <= '0;
            period_us    <= '0;
            period_valid <= 1'b0;
            ramp_state   <= RAMP_IDLE;
            stalled      <= 1'b0;
            done         <= 1'b0;
            us_cnt       <= '0;
            pre          <= '0;
            first        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (edge_ok) begin
                pulse_count <= cnt_inc;
                us_cnt      <= '0;
                pre         <= '0;
                stalled     <= 1'b0;
                first       <= state != S_RUN;
                // the interval before the first edge or across a stall is not a period
                if (state == S_RUN) begin
                    period_us    <= us_cnt;
                    period_valid <= 1'b1;
                    ramp_state   <= ramp_new;
                end
                if (hit_done) begin
                    done       <= 1'b1;
                    ramp_state <= RAMP_IDLE;
                end
            end else if (active) begin
                pre <= us_tick ? '0 : pre + 1'b1;
                if (us_tick && us_cnt != MAX)
                    us_cnt <= us_cnt + 1'b1;
                if (state == S_RUN && timeout_hit) begin
                    stalled    <= 1'b1;
                    ramp_state <= RAMP_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_pti_capture.sv
// tb_pti_capture: directed pulse trains with a queued scoreboard of expected period reports.
module tb_pti_capture;
    import pti_pkg::*;

    localparam int CPU = 2;
    localparam int TOL = 1;

    logic        clk = 0, rst = 1, enable = 0, clear = 0, pulse_in = 0;
    logic [31:0] timeout_us = 0, pulse_expected = 0;
    logic [31:0] pulse_count, period_us;
    logic        period_valid, stalled, done;
    logic [1:0]  ramp_state;

    pti_capture #(.CLK_PER_US(CPU), .FILT_LEN(3), .TOL_US(TOL)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .clear         (clear),
        .pulse_in      (pulse_in),
        .timeout_us    (timeout_us),
        .pulse_expected(pulse_expected),
        .pulse_count   (pulse_count),
        .period_us     (period_us),
        .period_valid  (period_valid),
        .ramp_state    (ramp_state),
        .stalled       (stalled),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cnt;
        int         per;
        logic [1:0] ramp;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int   checks = 0, errors = 0;
    int   exp_cnt = 0, prev_hl = 0, pp = -1;
    bit   have_prev = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ramp_of(input int p, input int prev);
        if (prev < 0) return RAMP_CONST;
        if (p + TOL < prev) return RAMP_ACCEL;
        if (p > prev + TOL) return RAMP_DECEL;
        return RAMP_CONST;
    endfunction

    // Model of one accepted edge; hl is the nominal length (us) of the pulse it starts.
    task automatic note_edge(input int hl);
        exp_t e;
        if (pulse_expected != 0 && exp_cnt == int'(pulse_expected)) return;
        exp_cnt++;
        if (have_prev) begin
            e.cnt  = exp_cnt;
            e.per  = prev_hl;
            e.ramp = (exp_cnt == int'(pulse_expected)) ? RAMP_IDLE : ramp_of(prev_hl, pp);
            q.push_back(e);
            pp = prev_hl;
        end
        have_prev = 1;
        prev_hl   = hl;
    endtask

    // g > 0 inserts a g-cycle dip mid-high and a g-cycle spike mid-low.
    task automatic pulse(input int h, input int l, input int g);
        note_edge(h + l);
        pulse_in = 1;
        repeat (h * CPU / 2) @(negedge clk);
        pulse_in = (g == 0);
        repeat (g) @(negedge clk);
        pulse_in = 1;
        repeat (h * CPU - h * CPU / 2 - g) @(negedge clk);
        pulse_in = 0;
        repeat (l * CPU / 2) @(negedge clk);
        pulse_in = (g != 0);
        repeat (g) @(negedge clk);
        pulse_in = 0;
        repeat (l * CPU - l * CPU / 2 - g) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cnt"}, pulse_count, 0);
        chk({tag, "_period"}, period_us, 0);
        chk({tag, "_pvalid"}, period_valid, 0);
        chk({tag, "_ramp"}, ramp_state, RAMP_IDLE);
        chk({tag, "_stalled"}, stalled, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic restart();
        clear = 1;
        @(negedge clk);
        clear     = 0;
        exp_cnt   = 0;
        have_prev = 0;
        pp        = -1;
    endtask

    // The measured period may lose the tick that coincides with the edge cycle.
    always @(negedge clk) begin
        if (!rst && period_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_period: got period_us=%0d count=%0d, required no report", period_us, pulse_count);
            end else begin
                got = q.pop_front();
                if (pulse_count !== got.cnt || ramp_state !== got.ramp ||
                    !(period_us == got.per || period_us == got.per - 1)) begin
                    errors++;
                    $display("FAIL period_report: got count=%0d period=%0d ramp=%0d, required count=%0d period=%0d(or -1) ramp=%0d",
                             pulse_count, period_us, ramp_state, got.cnt, got.per, got.ramp);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst    = 0;
        enable = 1;
        @(negedge clk);

        repeat (10) pulse(100, 100, 0);
        chk("basic_cnt", pulse_count, 10);
        chk("basic_ramp", ramp_state, RAMP_CONST);
        chk("basic_drain", q.size(), 0);
        restart();
        check_zero("clear1");

        for (int p = 60; p >= 40; p -= 2) pulse(p / 2, p - p / 2, 0);
        chk("ramp_accel", ramp_state, RAMP_ACCEL);
        repeat (5) pulse(20, 20, 0);
        chk("ramp_const", ramp_state, RAMP_CONST);
        for (int p = 42; p <= 60; p += 2) pulse(p / 2, p - p / 2, 0);
        chk("ramp_decel", ramp_state, RAMP_DECEL);
        chk("ramp_drain", q.size(), 0);
        restart();

        repeat (6) pulse(20, 20, 2);
        chk("glitch_cnt", pulse_count, 6);
        restart();

        timeout_us = 1000;
        repeat (4) pulse(50, 50, 0);
        note_edge(100);
        pulse_in = 1;
        n = 0;
        while (pulse_count != 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_edge5", pulse_count, 5);
        n = 0;
        while (!stalled && n < 3000 * CPU) begin
            @(negedge clk);
            n++;
            if (n == 50 * CPU) pulse_in = 0;
        end
        checks++;
        if (n < 1000 * CPU - 2 || n > 1000 * CPU + 2) begin
            errors++;
            $display("FAIL stall_time: got %0d cycles, required %0d +/-2", n, 1000 * CPU);
        end
        chk("stall_ramp", ramp_state, RAMP_IDLE);
        have_prev = 0;
        pp        = -1;
        pulse(50, 50, 0);
        chk("stall_clear", stalled, 0);
        chk("stall_cnt", pulse_count, 6);
        chk("stall_drain", q.size(), 0);
        timeout_us = 0;
        restart();

        pulse_expected = 400;
        repeat (405) pulse(10, 10, 0);
        chk("done_flag", done, 1);
        chk("done_cnt", pulse_count, 400);
        chk("done_ramp", ramp_state, RAMP_IDLE);
        chk("done_drain", q.size(), 0);
        restart();
        check_zero("clear_done");
        pulse_expected = 0;

        enable   = 0;
        pulse_in = 1;
        repeat (20) @(negedge clk);
        chk("disabled_cnt", pulse_count, 0);
        enable = 1;
        repeat (20) @(negedge clk);
        chk("reenable_cnt", pulse_count, 0);
        pulse_in = 0;
        repeat (20) @(negedge clk);
        pulse(10, 10, 0);
        chk("idle_first_cnt", pulse_count, 1);
        restart();

        repeat (37) pulse(10, 10, 0);
        chk("mid_cnt", pulse_count, 37);
        rst = 1;
        @(negedge clk);
        check_zero("rst_mid");
        rst       = 0;
        exp_cnt   = 0;
        have_prev = 0;
        pp        = -1;
        pulse(10, 10, 0);
        chk("after_rst_cnt", pulse_count, 1);
        chk("final_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
